// File: rtl/steer_pkg.sv
// Shared types and default thresholds for the steering-enable controller.
package steer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEER = 2'd2
    } state_t;

    localparam int unsigned DEF_LOAD_W           = 12;
    localparam int unsigned DEF_MIN_RIDER_WEIGHT = 32'h200;
    localparam int unsigned DEF_HYSTERESIS       = 32'h020;
    localparam int unsigned DEF_SETTLE_CYCLES    = 32'd67108864;
    localparam int unsigned DEF_OFF_SAMPLES      = 4;

    // Terminal count of the settle timer; FAST_SIM shrinks it by 2048 (never below 1).
    function automatic int unsigned term_count(input int unsigned settle, input int unsigned fast);
        if (fast == 0) return settle;
        if ((settle / 2048) == 0) return 1;
        return settle / 2048;
    endfunction

endpackage

// File: rtl/steer_en_ctrl_settle_timer.sv
// Saturating settle timer: full goes high after TERM enabled cycles since the last clear.
module settle_timer
    import steer_pkg::*;
#(
    parameter int unsigned TERM = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic full
);

    localparam int unsigned CW = (TERM > 1) ? $clog2(TERM) : 1;

    logic [CW-1:0] cnt;

    // Counter stops at TERM-1; the step that would reach TERM sets the sticky full flag instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            full <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            full <= 1'b0;
        end else if (en && !full) begin
            if (cnt == CW'(TERM - 1)) full <= 1'b1;
            else                      cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/steer_en_ctrl.sv
// Steering-enable controller: load-cell weight/balance checks, settle timer, rider-off pulse.
// Optional rider-off debounce is compiled in with `define STEER_OFF_DEBOUNCE_EN.
module steer_en_ctrl
    import steer_pkg::*;
#(
    parameter int unsigned LOAD_W           = DEF_LOAD_W,
    parameter int unsigned MIN_RIDER_WEIGHT = DEF_MIN_RIDER_WEIGHT,
    parameter int unsigned HYSTERESIS       = DEF_HYSTERESIS,
    parameter int unsigned SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
    parameter int unsigned FAST_SIM         = 0,
    parameter int unsigned OFF_SAMPLES      = DEF_OFF_SAMPLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld,
    input  logic [LOAD_W-1:0] lft_load,
    input  logic [LOAD_W-1:0] rght_load,
    output logic              en_steer,
    output logic              rider_off,
    output state_t            state
);

    localparam int unsigned SW     = LOAD_W + 1;
    localparam int unsigned XW     = LOAD_W + 5;
    localparam int unsigned HI_THR = MIN_RIDER_WEIGHT + HYSTERESIS;
    localparam int unsigned LO_THR = (MIN_RIDER_WEIGHT > HYSTERESIS) ? (MIN_RIDER_WEIGHT - HYSTERESIS) : 0;
    localparam int unsigned TERM   = term_count(SETTLE_CYCLES, FAST_SIM);

    logic [SW-1:0]     sum_c;
    logic [SW-1:0]     diff_c;
    logic [LOAD_W-1:0] absdiff_c;
    logic [XW-1:0]     sum_15_16_c;
    logic              sum_gt_min_c;
    logic              sum_lt_min_c;
    logic              diff_gt_1_4_c;
    logic              diff_gt_15_16_c;
    logic              off_det_c;
    logic              tmr_clr_c;
    logic              tmr_en_c;
    logic              tmr_full;

    // Weight and balance comparators on the current sample.
    always_comb begin
        sum_c           = SW'(lft_load) + SW'(rght_load);
        diff_c          = SW'(lft_load) - SW'(rght_load);
        absdiff_c       = diff_c[LOAD_W] ? LOAD_W'(-diff_c) : diff_c[LOAD_W-1:0];
        sum_15_16_c     = XW'(sum_c >> 4) * XW'(15);
        sum_gt_min_c    = 32'(sum_c) > HI_THR;
        sum_lt_min_c    = 32'(sum_c) < LO_THR;
        diff_gt_1_4_c   = SW'(absdiff_c) > (sum_c >> 2);
        diff_gt_15_16_c = XW'(absdiff_c) > sum_15_16_c;
    end

`ifdef STEER_OFF_DEBOUNCE_EN
    localparam int unsigned OW = (OFF_SAMPLES > 1) ? $clog2(OFF_SAMPLES) : 1;

    logic [OW-1:0] off_cnt;

    // Rider-off fires on the sample that completes OFF_SAMPLES consecutive low readings.
    always_comb begin
        off_det_c = vld && sum_lt_min_c && (off_cnt == OW'(OFF_SAMPLES - 1));
    end

    // Consecutive low-weight sample counter, active only while a rider is on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_cnt <= '0;
        end else if ((state != WAIT) && (state != STEER)) begin
            off_cnt <= '0;
        end else if (vld) begin
            if (off_det_c)         off_cnt <= '0;
            else if (sum_lt_min_c) off_cnt <= off_cnt + OW'(1);
            else                   off_cnt <= '0;
        end
    end
`else
    logic unused_off_samples;

    // A single low-weight sample is enough for rider-off.
    always_comb begin
        off_det_c          = vld && sum_lt_min_c;
        unused_off_samples = ^OFF_SAMPLES;
    end
`endif

    // Settle timer runs in WAIT; restarted in IDLE and whenever balance is lost.
    always_comb begin
        tmr_en_c  = (state == WAIT);
        tmr_clr_c = ((state != WAIT) && (state != STEER)) ||
                    (vld && !off_det_c &&
                     (((state == WAIT) && diff_gt_1_4_c) ||
                      ((state == STEER) && diff_gt_15_16_c)));
    end

    settle_timer #(
        .TERM (TERM)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr_c),
        .en    (tmr_en_c),
        .full  (tmr_full)
    );

    // State machine with registered en_steer and one-cycle rider_off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            en_steer  <= 1'b0;
            rider_off <= 1'b0;
        end else begin
            rider_off <= 1'b0;
            case (state)
                IDLE: begin
                    en_steer <= 1'b0;
                    if (vld && sum_gt_min_c) state <= WAIT;
                end
                WAIT: begin
                    if (off_det_c) begin
                        state     <= IDLE;
                        rider_off <= 1'b1;
                    end else if (vld && !diff_gt_1_4_c && tmr_full) begin
                        state    <= STEER;
                        en_steer <= 1'b1;
                    end
                end
                STEER: begin
                    if (off_det_c) begin
                        state     <= IDLE;
                        en_steer  <= 1'b0;
                        rider_off <= 1'b1;
                    end else if (vld && diff_gt_15_16_c) begin
                        state    <= WAIT;
                        en_steer <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    en_steer <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Self-checking bench for steer_en_ctrl: directed scenarios plus randomized segments
// checked every cycle against an integer-arithmetic reference model.
module tb_steer_en_ctrl;
    import steer_pkg::*;

    localparam int LOAD_W = 12;
    localparam int MINW   = 'h200;
    localparam int HYST   = 'h020;
    localparam int SETTLE = 2**16;
    localparam int OFFN   = 4;
    localparam int TERM   = SETTLE / 2048;
    localparam int HI     = MINW + HYST;
    localparam int LO     = MINW - HYST;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              vld   = 1'b0;
    logic [LOAD_W-1:0] lft   = '0;
    logic [LOAD_W-1:0] rght  = '0;
    logic              en_steer;
    logic              rider_off;
    state_t            state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    steer_en_ctrl #(
        .LOAD_W           (LOAD_W),
        .MIN_RIDER_WEIGHT (MINW),
        .HYSTERESIS       (HYST),
        .SETTLE_CYCLES    (SETTLE),
        .FAST_SIM         (1),
        .OFF_SAMPLES      (OFFN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld       (vld),
        .lft_load  (lft),
        .rght_load (rght),
        .en_steer  (en_steer),
        .rider_off (rider_off),
        .state     (state)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0=idle, 1=wait, 2=steer; age = clk cycles since timer restart.
    int m_state = 0;
    int m_age   = 0;
    int m_low   = 0;
    int m_en    = 0;
    int m_roff  = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int s, ad, nxt, roff;
        bit lo, hi, d14, d1516, full, off, clr;
        if (!rst_n) begin
            m_state = 0; m_age = 0; m_low = 0; m_en = 0; m_roff = 0;
        end else begin
            s     = int'(lft) + int'(rght);
            ad    = (lft > rght) ? int'(lft) - int'(rght) : int'(rght) - int'(lft);
            lo    = s < LO;
            hi    = s > HI;
            d14   = ad > s / 4;
            d1516 = ad > 15 * (s / 16);
            full  = m_age >= TERM;
            nxt   = m_state;
            roff  = 0;
            clr   = (m_state == 0);
`ifdef STEER_OFF_DEBOUNCE_EN
            off = vld && lo && (m_state != 0) && (m_low + 1 >= OFFN);
`else
            off = vld && lo;
`endif
            if (vld) begin
                if (m_state == 0) begin
                    if (hi) nxt = 1;
                end else if (off) begin
                    nxt = 0; roff = 1;
                end else if (m_state == 1) begin
                    if (d14) clr = 1;
                    else if (full) nxt = 2;
                end else begin
                    if (d1516) begin nxt = 1; clr = 1; end
                end
            end
            if (m_state == 0 || off) m_low = 0;
            else if (vld) m_low = lo ? m_low + 1 : 0;
            if (clr) m_age = 0;
            else if (m_state == 1 && m_age < TERM) m_age = m_age + 1;
            m_state = nxt;
            m_en    = (nxt == 2) ? 1 : 0;
            m_roff  = roff;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("state", int'(state), m_state);
        check("en_steer", int'(en_steer), m_en);
        check("rider_off", int'(rider_off), m_roff);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_in(input bit v, input int l, input int r);
        vld  = v;
        lft  = LOAD_W'(l);
        rght = LOAD_W'(r);
    endtask

    task automatic wait_en(input int budget, output int n);
        n = 0;
        while (en_steer !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
    endtask

    int n;
    int mode, seg, base;

    initial begin
        #1 rst_n = 1'b0;
        step(3);
        check("rst_state", int'(state), 0);
        check("rst_en", int'(en_steer), 0);
        check("rst_roff", int'(rider_off), 0);
        rst_n = 1'b1;

        set_in(0, 'h300, 'h300);
        step(50);
        check("novld_idle", int'(state), 0);

        set_in(1, 'h150, 'h150);
        step(1);
        check("enter_wait", int'(state), 1);
        check("wait_en_low", int'(en_steer), 0);
        wait_en(100, n);
        check("settle_latency", n, 33);
        check("in_steer", int'(state), 2);

        set_in(1, 'h380, 'h010);
        step(1);
        check("steer_to_wait", int'(state), 1);
        check("steer_drop_en", int'(en_steer), 0);
        set_in(1, 'h0F0, 'h0F0);
        step(5);
        check("band_hold_wait", int'(state), 1);
        set_in(1, 'h150, 'h150);
        step(14);
        set_in(1, 'h300, 'h050);
        step(1);
        check("diff_stay_wait", int'(state), 1);
        set_in(1, 'h150, 'h150);
        wait_en(100, n);
        check("restart_latency", n, 33);

`ifdef STEER_OFF_DEBOUNCE_EN
        set_in(1, 'h0C0, 'h0C0);
        step(3);
        check("low3_hold", int'(state), 2);
        set_in(1, 'h150, 'h150);
        step(1);
        check("low_break_hold", int'(state), 2);
        set_in(1, 'h0C0, 'h0C0);
        step(3);
        check("low3b_hold", int'(state), 2);
        check("low3b_roff", int'(rider_off), 0);
        step(1);
`else
        set_in(1, 'h0C0, 'h0C0);
        step(1);
`endif
        check("off_idle", int'(state), 0);
        check("off_pulse", int'(rider_off), 1);
        check("off_en", int'(en_steer), 0);
        step(1);
        check("off_pulse_end", int'(rider_off), 0);

        set_in(1, 'h150, 'h150);
        step(1);
        check("reenter_wait", int'(state), 1);
        wait_en(100, n);
        check("reenter_latency", n, 33);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_en", int'(en_steer), 0);
        check("mid_rst_roff", int'(rider_off), 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        check("post_rst_roff", int'(rider_off), 0);
        check("post_rst_wait", int'(state), 1);

        for (int k = 0; k < 150; k++) begin
            mode = $urandom_range(0, 5);
            seg  = $urandom_range(1, 50);
            for (int c = 0; c < seg; c++) begin
                vld = ($urandom_range(0, 9) < 8);
                case (mode)
                    0, 5: begin
                        base = $urandom_range('h120, 'h200);
                        lft  = LOAD_W'(base);
                        rght = LOAD_W'(base + $urandom_range(0, 6) - 3);
                    end
                    1: begin
                        base = $urandom_range('hE0, 'h120);
                        lft  = LOAD_W'(base);
                        rght = LOAD_W'(base + $urandom_range(0, 16) - 8);
                    end
                    2: begin
                        lft  = LOAD_W'($urandom_range(0, 'hD0));
                        rght = LOAD_W'($urandom_range(0, 'hD0));
                    end
                    3: begin
                        lft  = LOAD_W'($urandom_range('h200, 'hFFF));
                        rght = LOAD_W'($urandom_range(0, 'h100));
                    end
                    default: begin
                        lft  = LOAD_W'($urandom_range(0, 'hFFF));
                        rght = LOAD_W'($urandom_range(0, 'hFFF));
                    end
                endcase
                step(1);
            end
        end

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/steer_en_ctrl.md
# steer_en_ctrl

Parametrised steering-enable controller for the Segway. Replaces the fixed 12-bit steering-enable state machine. It takes left/right load-cell samples from the A2D interface, applies min-weight hysteresis and balance checks, and runs a settle timer. It drives `en_steer` to balance control and a one-cycle `rider_off` pulse to the power/shutdown logic. New in this generation: configurable width, thresholds and settle time; a sample-valid qualifier; an exported state; and optional rider-off debounce.

## Interface
- `LOAD_W`, 12: width of each load-cell sample.
- `MIN_RIDER_WEIGHT`, 'h200: rider-present threshold on the sum.
- `HYSTERESIS`, 'h020: band either side of `MIN_RIDER_WEIGHT`.
- `SETTLE_CYCLES`, 2**26: clk cycles a rider must be balanced before steering is enabled (about 1.34 s at 50 MHz).
- `FAST_SIM`, 0: when 1, the terminal count becomes `SETTLE_CYCLES`/2048 (minimum 1).
- `OFF_SAMPLES`, 4: consecutive low-weight samples needed for rider-off. Used only with debounce compiled in.
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `vld`  in  1  `lft_load`/`rght_load` hold a new A2D sample this cycle.
- `lft_load`  in  `LOAD_W`  left load cell, unsigned.
- `rght_load`  in  `LOAD_W`  right load cell, unsigned.
- `en_steer`  out  1  steering enabled. High iff state == STEER.
- `rider_off`  out  1  one-cycle pulse on any return to IDLE.
- `state`  out  2  current state (`state_t` encoding).

## Operation
- Arithmetic:
  - sum = lft + rght, computed in `LOAD_W`+1 bits.
  - diff = lft − rght, computed signed in `LOAD_W`+1 bits (no overflow).
  - absdiff is `LOAD_W` bits.
- Threshold comparisons:
  - sum_gt_min = sum > `MIN_RIDER_WEIGHT` + `HYSTERESIS`.
  - sum_lt_min = sum < `MIN_RIDER_WEIGHT` − `HYSTERESIS`.
  - diff_gt_1_4 = absdiff > (sum>>2).
  - diff_gt_15_16 = absdiff > 15*(sum>>4), evaluated in `LOAD_W`+5 bits.
- The comparators and the state machine act only on cycles with `vld`=1. Without `vld`, the state holds.
- The timer counts every clk while in WAIT, and saturates at terminal count (tmr_full).
- State machine transitions, in priority order within each state:
  - IDLE: sum_gt_min → WAIT, and clear the timer.
  - WAIT: off_det → IDLE with `rider_off`. Else diff_gt_1_4 → clear the timer and stay in WAIT. Else tmr_full → STEER. Else stay.
  - STEER: off_det → IDLE with `rider_off`. Else diff_gt_15_16 → WAIT, and clear the timer. Else stay.
- off_det equals sum_lt_min, unless debounce is compiled in (see Configuration).
- The timer is also cleared in IDLE.
- Sums inside the hysteresis band cause no transition from IDLE.
- Illegal state encoding → IDLE next cycle, with no `rider_off` pulse.

## Timing
- Reset values:
  - state = IDLE.
  - `en_steer` = 0.
  - `rider_off` = 0.
  - Timer = 0.
  - Debounce counter = 0.
- Reset mid-operation forces IDLE immediately, with no `rider_off` pulse.
- State is registered. Every transition takes effect at the clk edge ending the `vld` cycle.
- `en_steer` follows state. It rises the cycle after the STEER transition and falls the cycle after leaving STEER.
- `rider_off` is registered. It is high for exactly one cycle, the same cycle state first reads IDLE.
- Settle timing:
  - The timer is cleared on the IDLE→WAIT edge, so tmr_full asserts `SETTLE_CYCLES` clk cycles after entering WAIT.
  - STEER is entered on the first `vld` sample at or after tmr_full.
- Simultaneous events: off_det wins over the diff checks and over tmr_full.

## Configuration
- `STEER_OFF_DEBOUNCE_EN` defined:
  - In WAIT/STEER, an `OFF_SAMPLES`-deep counter increments on each `vld` sample with sum_lt_min, and resets to 0 on any `vld` sample without it.
  - off_det is asserted on the sample that makes the count reach `OFF_SAMPLES`.
  - The counter clears on entering IDLE.
- Undefined: off_det = sum_lt_min on a single `vld` sample, and the counter logic is absent.

## Structure
- Package `steer_pkg`:
  - `state_t` enum {IDLE=0, WAIT=1, STEER=2}.
  - Default threshold constants.
- Sub-module `settle_timer`:
  - Parameters: terminal count.
  - Inputs: clk, rst_n, `clr`, `en`.
  - Output: `full`.
  - Width is `$clog2` of the terminal count; the counter saturates.

## Test plan
- `FAST_SIM`=1, `SETTLE_CYCLES`=2**16 (terminal 32), lft=rght='h150 on every cycle with `vld` → WAIT next cycle, `en_steer`=1 exactly 32+1 cycles later.
- In WAIT, lft='h300, rght='h050 (absdiff 'h2B0 > 'hD4) at cycle 20 → timer restarts, STEER delayed by a further 32 cycles.
- In STEER, lft='h380, rght='h010 → WAIT, `en_steer` drops next cycle. Then lft=rght='h0F0 (sum 'h1E0, inside the band) → stays WAIT.
- In STEER, lft=rght='h0C0 (sum 'h180 < 'h1E0):
  - Debounce off: `rider_off` pulse one cycle, then IDLE.
  - Debounce on: 3 low samples then 1 normal sample → stays STEER. 4 consecutive low samples → `rider_off`.
- `vld`=0 throughout with loads above threshold → state stays IDLE indefinitely.
- Assert `rst_n` low while in STEER → state=IDLE, `en_steer`=0, no `rider_off` pulse.
